// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU mux selector sequencer with shift-add multiplier
module alu_op_sequencer #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [2:0]       Selector,
  output logic [WIDTH-1:0] MulResult,
  output logic             Busy,
  output logic             Done,
  output logic             IllegalOp
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_MUL    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic             accept, op_illegal, op_mul, last_iter;

  assign accept     = (state == S_IDLE) && Start;
  assign op_illegal = ALUOp[2] & ALUOp[1];
  assign op_mul     = (ALUOp == OP_MUL);
  assign last_iter  = (cnt == LAST_ITER);
  // Partial-product add for the current iteration; carries out of WIDTH are dropped.
  assign acc_next   = mplier[0] ? (acc + mcand) : acc;

  // Busy/Done decode only the state register, so neither sees the inputs.
  assign Busy = (state != S_IDLE);
  assign Done = (state == S_SINGLE) || (state == S_DONE);

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: requests are honoured only in IDLE and never queued.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && !op_illegal) state_next = op_mul ? S_MUL : S_SINGLE;
      end
      S_SINGLE: state_next = S_IDLE;
      S_MUL: begin
        if (last_iter) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Selector follows each accepted legal opcode and holds otherwise.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                  Selector <= 3'b000;
    else if (accept && !op_illegal) Selector <= ALUOp;
  end

  // Illegal-opcode pulse lasts exactly the cycle after the accepting edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) IllegalOp <= 1'b0;
    else          IllegalOp <= accept && op_illegal;
  end

  // Shift-add multiplier: operands latched on accept, one bit retired per MUL cycle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && op_mul) begin
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Product register updates only when the final iteration retires.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                         MulResult <= '0;
    else if ((state == S_MUL) && last_iter) MulResult <= acc_next;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  localparam int W = 24;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic         Start;
  logic [2:0]   ALUOp;
  logic [W-1:0] A, B;
  logic [2:0]   Selector;
  logic [W-1:0] MulResult;
  logic         Busy, Done, IllegalOp;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .ALUOp(ALUOp),
    .A(A), .B(B), .Selector(Selector), .MulResult(MulResult),
    .Busy(Busy), .Done(Done), .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  // Reference model: remaining busy cycles plus the values the outputs should show.
  int           rem;
  logic [2:0]   m_sel;
  logic [W-1:0] m_res, m_pend;
  logic         m_ill;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    rem = 0; m_sel = 3'b000; m_res = '0; m_pend = '0; m_ill = 1'b0;
  endtask

  task automatic model_edge();
    logic [2*W-1:0] full;
    m_ill = 1'b0;
    if (rem == 0) begin
      if (Start) begin
        if (ALUOp == 3'd6 || ALUOp == 3'd7) begin
          m_ill = 1'b1;
        end else if (ALUOp == 3'd4) begin
          full   = A * B;
          m_pend = full[W-1:0];
          m_sel  = 3'd4;
          rem    = W + 1;
        end else begin
          m_sel = ALUOp;
          rem   = 1;
        end
      end
    end else begin
      rem--;
      if (rem == 1) m_res = m_pend;
    end
  endtask

  task automatic check_outputs();
    check("selector",  32'(Selector),  32'(m_sel));
    check("mulresult", 32'(MulResult), 32'(m_res));
    check("busy",      32'(Busy),      32'(rem > 0));
    check("done",      32'(Done),      32'(rem == 1));
    check("illegalop", 32'(IllegalOp), 32'(m_ill));
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, check at the next negedge.
  task automatic cycle(input logic s, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = s; ALUOp = op; A = a; B = b;
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    check_outputs();
  endtask

  task automatic do_reset();
    Start = 1'b0;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge Clock);
    check_outputs();
    Reset_n = 1'b1;
  endtask

  initial begin
    int done_at, busy_cnt, done_cnt;
    Start = 1'b0; ALUOp = 3'd0; A = '0; B = '0;
    Reset_n = 1'b0;
    model_reset();
    @(negedge Clock);
    check_outputs();
    Reset_n = 1'b1;

    // ADD then XOR, two cycles apart
    cycle(1'b1, 3'd2, 0, 0);
    check("add_sel", 32'(Selector), 32'd2);
    check("add_done", 32'(Done), 32'd1);
    cycle(1'b0, 3'd0, 0, 0);
    check("add_busy_drop", 32'(Busy), 32'd0);
    cycle(1'b1, 3'd5, 0, 0);
    check("xor_sel", 32'(Selector), 32'd5);
    cycle(1'b0, 3'd0, 0, 0);

    // MUL 3*5 with latency and busy-length measurement
    cycle(1'b1, 3'd4, 24'd3, 24'd5);
    check("mul_sel", 32'(Selector), 32'd4);
    busy_cnt = Busy ? 1 : 0;
    done_at  = -1;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b0, 3'd0, 0, 0);
      if (Busy) busy_cnt++;
      if (Done && done_at < 0) done_at = k;
    end
    check("mul_done_latency", 32'(done_at), 32'(W));
    check("mul_busy_cycles", 32'(busy_cnt), 32'(W + 1));
    check("mul_3x5", 32'(MulResult), 32'd15);

    // Overflow cases
    cycle(1'b1, 3'd4, 24'hFFFFFF, 24'd2);
    for (int k = 0; k < W + 1; k++) cycle(1'b0, 3'd0, 0, 0);
    check("mul_ovf1", 32'(MulResult), 32'hFFFFFE);
    cycle(1'b1, 3'd4, 24'h800000, 24'h000002);
    for (int k = 0; k < W + 1; k++) cycle(1'b0, 3'd0, 0, 0);
    check("mul_ovf2", 32'(MulResult), 32'h0);

    // Start during MUL cycle 10 is ignored
    cycle(1'b1, 3'd4, 24'd1234, 24'd77);
    done_cnt = 0;
    for (int k = 1; k <= W + 4; k++) begin
      if (k == 10) cycle(1'b1, 3'd2, 0, 0);
      else         cycle(1'b0, 3'd0, 0, 0);
      if (Done) done_cnt++;
      if (k < W) check("mul_sel_hold", 32'(Selector), 32'd4);
    end
    check("mul_single_done", 32'(done_cnt), 32'd1);
    check("mul_1234x77", 32'(MulResult), 32'(1234 * 77));

    // Illegal opcode in IDLE
    cycle(1'b1, 3'd6, 0, 0);
    check("ill_pulse", 32'(IllegalOp), 32'd1);
    check("ill_busy", 32'(Busy), 32'd0);
    check("ill_sel", 32'(Selector), 32'd4);
    cycle(1'b0, 3'd0, 0, 0);
    check("ill_pulse_end", 32'(IllegalOp), 32'd0);

    // Reset mid-MUL at cycle 12
    cycle(1'b1, 3'd4, 24'd9, 24'd9);
    for (int k = 1; k < 12; k++) cycle(1'b0, 3'd0, 0, 0);
    do_reset();
    check("rst_mulres", 32'(MulResult), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < W + 4; k++) begin
      cycle(1'b0, 3'd0, 0, 0);
      if (Done) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);
    cycle(1'b1, 3'd1, 0, 0);
    check("rst_first_accept", 32'(Busy), 32'd1);
    cycle(1'b0, 3'd0, 0, 0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              W'($urandom), W'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
